axis_rr_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one downstream AXI-stream path (typically a skidbuffer stage feeding the header-insert datapath) among N upstream requesters.
- Grants one requester at a time and holds the grant until that requester's last beat is accepted.
- Forwards data/last/valid from the granted input and returns downstream ready only to the granted input.
- Sits directly upstream of the skidbuffer, so the downstream ready path is cut by the skidbuffer, not by this block.

---
 rtl/axis_rr_arbiter.sv | 115 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: N AXI-stream requesters share one
// downstream path. A grant is held from the first beat until the granted
// requester's last beat transfers, then one idle cycle re-arbitrates.
module axis_rr_arbiter #(
  parameter  int N  = 4,
  parameter  int DW = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N-1:0]    i_valid,
  input  logic [N*DW-1:0] i_data,
  input  logic [N-1:0]    i_last,
  output logic [N-1:0]    o_ready,
  output logic            o_valid,
  output logic [DW-1:0]   o_data,
  output logic            o_last,
  input  logic            i_ready,
  output logic [N-1:0]    o_grant,
  output logic [IW-1:0]   o_grant_idx,
  output logic            o_busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         grant_q, grant_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        sel_idx;
  logic                 sel_found;
  logic [2*N-1:0]       vld_dbl;
  logic [N-1:0]         vld_rot;
  logic [N-1:0][DW-1:0] data_arr;

  assign data_arr = i_data;

  // Rotate requests so bit 0 is the requester at the priority pointer.
  assign vld_dbl = {i_valid, i_valid} >> ptr_q;
  assign vld_rot = vld_dbl[N-1:0];

  // First set bit at or above the pointer, wrapping modulo N.
  always_comb begin
    logic [IW:0] sum;
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (vld_rot[i]) begin
        sel_found = 1'b1;
        sum       = {1'b0, ptr_q} + (IW+1)'(i);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        sel_idx   = sum[IW-1:0];
      end
    end
  end

  // State, grant and priority pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic and combinational forwarding from the granted input.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    o_valid = 1'b0;
    o_data  = '0;
    o_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = BUSY;
          idx_d   = sel_idx;
          grant_d = {{(N-1){1'b0}}, 1'b1} << sel_idx;
        end
      end
      BUSY: begin
        o_valid = i_valid[idx_q];
        o_data  = data_arr[idx_q];
        o_last  = i_last[idx_q];
        // Only the last beat of the held packet releases the grant.
        if (i_valid[idx_q] && i_ready && i_last[idx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (idx_q == IW'(N-1)) ? '0 : idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is steered purely from the registered grant, so no path from
  // any i_valid reaches o_ready.
  for (genvar k = 0; k < N; k++) begin : g_rdy
    assign o_ready[k] = grant_q[k] & i_ready;
  end

  assign o_grant     = grant_q;
  assign o_grant_idx = idx_q;
  assign o_busy      = (state_q == BUSY);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: per-requester source queues feed the DUT and a
// scoreboard of expected downstream beats is checked on every transfer.
module tb_axis_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [N-1:0]    i_valid;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    i_last;
  logic [N-1:0]    o_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic            o_last;
  logic            i_ready;
  logic [N-1:0]    o_grant;
  logic [IW-1:0]   o_grant_idx;
  logic            o_busy;

  int checks   = 0;
  int failures = 0;

  logic [DW:0]  src_q [N][$];  // {last, data}
  logic [DW:0]  exp_q [$];
  logic [N-1:0] hold;
  logic [N-1:0] fire;

  axis_rr_arbiter #(.N(N), .DW(DW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .i_last(i_last), .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
    .o_last(o_last), .i_ready(i_ready), .o_grant(o_grant),
    .o_grant_idx(o_grant_idx), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW:0] mkbeat(int k, int b, int n, int tag);
    logic [DW-1:0] d;
    d = DW'((k << 4) | ((tag + b) & 15));
    return {(b == n-1), d};
  endfunction

  task automatic push_src(int k, int n, int tag);
    for (int b = 0; b < n; b++) src_q[k].push_back(mkbeat(k, b, n, tag));
  endtask

  task automatic push_exp(int k, int n, int tag);
    for (int b = 0; b < n; b++) exp_q.push_back(mkbeat(k, b, n, tag));
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0 && !hold[k]) begin
        i_valid[k]           = 1'b1;
        i_data[k*DW +: DW]   = src_q[k][0][DW-1:0];
        i_last[k]            = src_q[k][0][DW];
      end else begin
        i_valid[k]           = 1'b0;
        i_data[k*DW +: DW]   = '0;
        i_last[k]            = 1'b0;
      end
    end
  endtask

  // Sources: note which requesters handshake, then advance them after the edge.
  always @(negedge clk) fire = i_reset ? '0 : (o_ready & i_valid);

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++)
      if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    fire = '0;
    drive_inputs();
  end

  // Scoreboard: each downstream transfer must match the next expected beat.
  always @(negedge clk) begin
    if (!i_reset && o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat: unexpected beat %h last=%0b, none expected", o_data, o_last);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        if ({o_last, o_data} !== e) begin
          failures++;
          $display("FAIL beat: got last=%0b data=%h, want last=%0b data=%h",
                   o_last, o_data, e[DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit srcs_empty();
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(int budget);
    int c;
    c = 0;
    while (!(exp_q.size() == 0 && srcs_empty()) && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (!(exp_q.size() == 0 && srcs_empty())) begin
      failures++;
      $display("FAIL drain: %0d beats still expected after %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic reset_pulse();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic check_idle_zero(string tag);
    checks++;
    if ({o_ready, o_valid, o_data, o_last, o_grant, o_grant_idx, o_busy} !== '0) begin
      failures++;
      $display("FAIL %s: ready=%b valid=%b data=%h last=%b grant=%b idx=%0d busy=%b, want all 0",
               tag, o_ready, o_valid, o_data, o_last, o_grant, o_grant_idx, o_busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    check_idle_zero("reset_state");
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    push_src(2, 3, 1);
    push_exp(2, 3, 1);
    drive_inputs();
    tick();
    checks++;
    if (o_grant !== 4'b0100 || o_grant_idx !== 2'd2 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: grant=%b idx=%0d busy=%b, want 0100 2 1", o_grant, o_grant_idx, o_busy);
    end
    wait_drain(20);
    checks++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_release: grant=%b busy=%b valid=%b, want 0000 0 0", o_grant, o_busy, o_valid);
    end
  endtask

  task automatic test_round_robin();
    reset_pulse();
    push_src(0, 1, 0);
    push_src(0, 1, 5);
    for (int k = 1; k < N; k++) push_src(k, 1, 0);
    for (int k = 0; k < N; k++) push_exp(k, 1, 0);
    push_exp(0, 1, 5);
    drive_inputs();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (o_valid !== ((i % 2) == 0)) begin
        failures++;
        $display("FAIL rr_valid: cycle %0d valid=%b, want %0b", i, o_valid, (i % 2) == 0);
      end
      if ((i % 2) == 0) begin
        checks++;
        if (o_grant_idx !== IW'((i / 2) % N)) begin
          failures++;
          $display("FAIL rr_order: cycle %0d idx=%0d, want %0d", i, o_grant_idx, (i / 2) % N);
        end
      end
    end
    wait_drain(10);
  endtask

  task automatic test_backpressure();
    reset_pulse();
    push_src(1, 4, 2);
    push_src(3, 1, 9);
    push_exp(1, 4, 2);
    push_exp(3, 1, 9);
    drive_inputs();
    tick();
    for (int c = 0; c < 40 && src_q[1].size() > 0; c++) begin
      i_ready = ((c % 4) == 0) || ((c % 4) == 3);
      #1;
      checks++;
      if (o_ready !== (4'b0010 & {N{i_ready}})) begin
        failures++;
        $display("FAIL bp_ready: cycle %0d o_ready=%b i_ready=%b", c, o_ready, i_ready);
      end
      tick();
    end
    i_ready = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_grant_lock();
    reset_pulse();
    // Scenario A: only requester 0 joins while 2 is mid-packet and stalls.
    push_src(2, 4, 0);
    push_exp(2, 4, 0);
    drive_inputs();
    tick();
    push_src(0, 1, 7);
    push_exp(0, 1, 7);
    hold[2] = 1'b1;
    drive_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (o_busy !== 1'b1 || o_grant !== 4'b0100 || o_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL lock_hold: busy=%b grant=%b ready=%b, want 1 0100 xxx0", o_busy, o_grant, o_ready);
      end
    end
    hold[2] = 1'b0;
    drive_inputs();
    for (int c = 0; c < 20 && src_q[2].size() > 0; c++) begin
      checks++;
      if (o_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL lock_ready0: cycle %0d o_ready=%b, want bit0=0", c, o_ready);
      end
      tick();
    end
    wait_drain(20);
    // Scenario B: requesters 0 and 3 join; 3 follows 2 before 0.
    push_src(2, 2, 3);
    push_exp(2, 2, 3);
    drive_inputs();
    tick();
    push_src(0, 1, 1);
    push_src(3, 1, 1);
    push_exp(3, 1, 1);
    push_exp(0, 1, 1);
    drive_inputs();
    wait_drain(20);
  endtask

  task automatic test_wrap_skip();
    reset_pulse();
    push_src(2, 1, 4);
    push_exp(2, 1, 4);
    drive_inputs();
    wait_drain(10);
    tick();
    push_src(1, 1, 4);
    push_exp(1, 1, 4);
    drive_inputs();
    tick();
    checks++;
    if (o_grant !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_grant: grant=%b, want 0010", o_grant);
    end
    wait_drain(10);
    push_src(0, 1, 6);
    push_src(2, 1, 6);
    push_exp(2, 1, 6);
    push_exp(0, 1, 6);
    drive_inputs();
    tick();
    checks++;
    if (o_grant !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_ptr: grant=%b, want 0100", o_grant);
    end
    wait_drain(10);
  endtask

  task automatic test_reset_mid();
    tick();
    push_src(1, 4, 8);
    exp_q.push_back(mkbeat(1, 0, 4, 8));
    drive_inputs();
    tick();
    tick();
    i_reset = 1'b1;
    tick();
    for (int k = 0; k < N; k++) src_q[k].delete();
    drive_inputs();
    check_idle_zero("reset_mid");
    i_reset = 1'b0;
    push_src(3, 1, 2);
    push_src(0, 1, 2);
    push_exp(0, 1, 2);
    push_exp(3, 1, 2);
    drive_inputs();
    tick();
    checks++;
    if (o_grant !== 4'b0001) begin
      failures++;
      $display("FAIL reset_mid_regrant: grant=%b, want 0001", o_grant);
    end
    wait_drain(10);
  endtask

  initial begin
    i_reset = 1'b1;
    i_ready = 1'b1;
    hold    = '0;
    fire    = '0;
    i_valid = '0;
    i_data  = '0;
    i_last  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_grant_lock();
    test_wrap_skip();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
